// File: rtl/led_matrix_scan.sv
// led_matrix_scan: row-multiplexed LED matrix scanner with per-row blanking, global PWM dimming
// and per-row snapshots. Define LED_MATRIX_DBUF_EN for separate front/back frame buffers.
module led_matrix_scan #(
    parameter int p_row_num      = 8,
    parameter int p_column_num   = 8,
    parameter int p_control_num  = 3,
    parameter int p_pwm_bits     = 8,
    parameter int p_blank_cycles = 16,
    parameter int p_dwell_cycles = 4096
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic                                  wr_valid,
    output logic                                  wr_ready,
    input  logic [$clog2(p_row_num)-1:0]          wr_row,
    input  logic [$clog2(p_column_num)-1:0]       wr_col,
    input  logic [p_control_num-1:0]              wr_color,
    input  logic [p_pwm_bits-1:0]                 brightness,
    input  logic                                  swap_req,
    output logic                                  swap_ack,
    output logic                                  frame_start,
    output logic [p_row_num-1:0]                  row_anode,
    output logic [p_column_num*p_control_num-1:0] column_cell
);

    localparam int RW       = $clog2(p_row_num);
    localparam int CB       = p_control_num;
    localparam int PW       = p_pwm_bits;
    localparam int ROW_BITS = p_column_num * CB;
    localparam int FB_BITS  = p_row_num * ROW_BITS;
    localparam int TMAX     = (p_dwell_cycles > p_blank_cycles) ? p_dwell_cycles : p_blank_cycles;
    localparam int TW       = $clog2(TMAX);

    localparam logic [TW-1:0] BLANK_LOAD = TW'(p_blank_cycles - 1);
    localparam logic [TW-1:0] DWELL_LOAD = TW'(p_dwell_cycles - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(p_row_num - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         pwm_q, pwm_d;
    logic [PW-1:0]         bright_q, bright_d;
    logic [ROW_BITS-1:0]   snap_q, snap_d, snap_src;
    logic                  load_snap;
    logic                  frame_start_q, frame_start_d;
    logic [p_row_num-1:0]  row_anode_q, row_anode_d;
    logic [ROW_BITS-1:0]   column_cell_q, column_cell_d;
    logic [FB_BITS-1:0]    front_q;
    logic                  wr_en;
    int                    wr_base;

    assign wr_ready = !rst;
    // Out-of-range coordinates are still handshaken, just never stored.
    assign wr_en    = wr_valid && wr_ready &&
                      (int'(wr_row) < p_row_num) && (int'(wr_col) < p_column_num);
    assign wr_base  = int'(wr_row) * ROW_BITS + int'(wr_col) * CB;

`ifdef LED_MATRIX_DBUF_EN
    logic [FB_BITS-1:0] back_q;
    logic               pending_q;
    logic               swap_ack_q;
    logic               swap_now;

    // Swap lands on the frame boundary so a frame is never shown from two images.
    assign swap_now = pending_q &&
                      ((state_q == S_IDLE) ||
                       (state_q == S_DRIVE && row_q == ROW_LAST && cnt_q == '0));
    assign snap_src = swap_now ? back_q[int'(row_d)*ROW_BITS +: ROW_BITS]
                               : front_q[int'(row_d)*ROW_BITS +: ROW_BITS];
    assign swap_ack = swap_ack_q;
`else
    logic unused_swap_req;
    assign unused_swap_req = swap_req;
    assign snap_src        = front_q[int'(row_d)*ROW_BITS +: ROW_BITS];
    assign swap_ack        = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        cnt_d         = cnt_q;
        pwm_d         = pwm_q;
        bright_d      = bright_q;
        load_snap     = 1'b0;
        frame_start_d = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            row_d   = '0;
            cnt_d   = '0;
            pwm_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d       = S_BLANK;
                    row_d         = '0;
                    cnt_d         = BLANK_LOAD;
                    load_snap     = 1'b1;
                    bright_d      = brightness;
                    frame_start_d = 1'b1;
                end
                S_BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = S_DRIVE;
                        cnt_d   = DWELL_LOAD;
                        pwm_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_DRIVE: begin
                    pwm_d = pwm_q + 1'b1;
                    if (cnt_q == '0) begin
                        state_d   = S_BLANK;
                        cnt_d     = BLANK_LOAD;
                        pwm_d     = '0;
                        load_snap = 1'b1;
                        if (row_q == ROW_LAST) begin
                            row_d         = '0;
                            bright_d      = brightness;
                            frame_start_d = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    row_d   = '0;
                end
            endcase
        end
    end

    // Outputs are derived from next-state values so they line up with the registered state.
    always_comb begin
        snap_d        = load_snap ? snap_src : snap_q;
        row_anode_d   = '0;
        column_cell_d = '0;
        for (int r = 0; r < p_row_num; r++) begin
            if (state_d == S_DRIVE && row_d == RW'(r)) begin
                row_anode_d[r] = 1'b1;
            end
        end
        if (state_d == S_DRIVE && pwm_d < bright_d) begin
            column_cell_d = snap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            row_q         <= '0;
            cnt_q         <= '0;
            pwm_q         <= '0;
            bright_q      <= '0;
            snap_q        <= '0;
            frame_start_q <= 1'b0;
            row_anode_q   <= '0;
            column_cell_q <= '0;
            front_q       <= '0;
`ifdef LED_MATRIX_DBUF_EN
            back_q        <= '0;
            pending_q     <= 1'b0;
            swap_ack_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            cnt_q         <= cnt_d;
            pwm_q         <= pwm_d;
            bright_q      <= bright_d;
            snap_q        <= snap_d;
            frame_start_q <= frame_start_d;
            row_anode_q   <= row_anode_d;
            column_cell_q <= column_cell_d;
`ifdef LED_MATRIX_DBUF_EN
            pending_q  <= !swap_now && (pending_q || swap_req);
            swap_ack_q <= swap_now;
            if (swap_now) begin
                front_q <= back_q;
                back_q  <= front_q;
            end
            if (wr_en) begin
                back_q[wr_base +: CB] <= wr_color;
            end
`else
            if (wr_en) begin
                front_q[wr_base +: CB] <= wr_color;
            end
`endif
        end
    end

    assign frame_start = frame_start_q;
    assign row_anode   = row_anode_q;
    assign column_cell = column_cell_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Testbench for led_matrix_scan: frame-position reference model feeds a scoreboard queue that a
// monitor drains every cycle; directed phases plus randomized traffic.
`timescale 1ns/1ps
module tb_led_matrix_scan;
    localparam int R = 6, C = 6, CB = 3, PW = 4, BL = 3, DW = 20;
    localparam int SLOT  = BL + DW;
    localparam int FRAME = R * SLOT;
    localparam int RW = $clog2(R), CW = $clog2(C);

    logic              clk = 1'b0, rst = 1'b1, enable = 1'b0, wr_valid = 1'b0, swap_req = 1'b0;
    logic              wr_ready, swap_ack, frame_start;
    logic [RW-1:0]     wr_row = '0;
    logic [CW-1:0]     wr_col = '0;
    logic [CB-1:0]     wr_color = '0;
    logic [PW-1:0]     brightness = '0;
    logic [R-1:0]      row_anode;
    logic [C*CB-1:0]   column_cell;

    led_matrix_scan #(
        .p_row_num(R), .p_column_num(C), .p_control_num(CB),
        .p_pwm_bits(PW), .p_blank_cycles(BL), .p_dwell_cycles(DW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_col(wr_col), .wr_color(wr_color), .brightness(brightness),
        .swap_req(swap_req), .swap_ack(swap_ack), .frame_start(frame_start),
        .row_anode(row_anode), .column_cell(column_cell)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [R-1:0]    anode;
        logic [C*CB-1:0] cells;
        logic            fs;
        logic            sa;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0, n_fail = 0;
    bit   count_on = 1'b0;
    int   on_cnt = 0, ack_cnt = 0;

    // Reference: expected outputs follow from the cycle position inside the frame.
    logic [CB-1:0] m_front [R][C];
`ifdef LED_MATRIX_DBUF_EN
    logic [CB-1:0] m_back [R][C];
    bit            m_pend = 1'b0;
`endif
    logic [CB-1:0] m_snap [C];
    logic [PW-1:0] m_bright = '0;
    int            t = -1;

    always @(posedge clk) begin
        obs_t e;
        int   pos, row, off;
        bit   sw;
        e  = '0;
        sw = 1'b0;
        if (rst) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) begin
                    m_front[r][c] = '0;
`ifdef LED_MATRIX_DBUF_EN
                    m_back[r][c] = '0;
`endif
                end
            t        = -1;
            m_bright = '0;
`ifdef LED_MATRIX_DBUF_EN
            m_pend = 1'b0;
`endif
        end else begin
`ifdef LED_MATRIX_DBUF_EN
            sw = m_pend && (t < 0 || (t % FRAME) == FRAME - 1);
            if (sw)
                for (int r = 0; r < R; r++)
                    for (int c = 0; c < C; c++) begin
                        logic [CB-1:0] tmp;
                        tmp           = m_front[r][c];
                        m_front[r][c] = m_back[r][c];
                        m_back[r][c]  = tmp;
                    end
            m_pend = !sw && (m_pend || swap_req);
`endif
            t = enable ? t + 1 : -1;
            if (t >= 0) begin
                pos = t % FRAME;
                row = pos / SLOT;
                off = pos % SLOT;
                if (pos == 0) begin
                    m_bright = brightness;
                    e.fs     = 1'b1;
                end
                if (off == 0)
                    for (int c = 0; c < C; c++) m_snap[c] = m_front[row][c];
                if (off >= BL) begin
                    e.anode[row] = 1'b1;
                    if (((off - BL) % (1 << PW)) < int'(m_bright))
                        for (int c = 0; c < C; c++) e.cells[c*CB +: CB] = m_snap[c];
                end
            end
            if (wr_valid && int'(wr_row) < R && int'(wr_col) < C) begin
`ifdef LED_MATRIX_DBUF_EN
                m_back[wr_row][wr_col] = wr_color;
`else
                m_front[wr_row][wr_col] = wr_color;
`endif
            end
        end
        e.sa = sw;
        exp_q.push_back(e);
    end

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = {row_anode, column_cell, frame_start, swap_ack};
            n_tests++;
            if (a !== e || wr_ready !== !rst) begin
                n_fail++;
                $display("FAIL cycle_out @%0t: act anode=%b cells=%h fs=%b ack=%b rdy=%b, exp anode=%b cells=%h fs=%b ack=%b rdy=%b",
                         $time, a.anode, a.cells, a.fs, a.sa, wr_ready,
                         e.anode, e.cells, e.fs, e.sa, !rst);
            end
            if (count_on && row_anode == R'(4) && column_cell[5*CB +: CB] == 3'b101) on_cnt++;
            if (swap_ack === 1'b1) ack_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int r, input int c, input int col);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_row   = RW'(r);
        wr_col   = CW'(c);
        wr_color = CB'(col);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_swap();
        @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        for (int i = 1; i <= FRAME + 20; i++) begin
            @(posedge clk);
            #1;
            if (frame_start === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: act=%0d exp=%0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, exp_on, exp_ack;
        cyc(2);
        rst = 1'b0;

        // single lit pixel at full brightness
        wr(2, 5, 5);
        brightness = 4'hF;
        pulse_swap();
        cyc(3);
        @(negedge clk);
        enable   = 1'b1;
        count_on = 1'b1;
        cyc(2 * FRAME);
        count_on = 1'b0;
        exp_on = 0;
        for (int k = 0; k < DW; k++) if ((k % (1 << PW)) < (1 << PW) - 1) exp_on++;
        check("pixel_on_cycles", on_cnt, 2 * exp_on);

        // zero brightness frame, change takes effect only at the next frame
        @(negedge clk);
        enable     = 1'b0;
        brightness = '0;
        @(negedge clk);
        enable = 1'b1;
        cyc(FRAME / 2);
        brightness = 4'd8;
        cyc(FRAME + FRAME / 2);

        // out-of-range writes are swallowed
        wr(6, 0, 7);
        wr(0, 6, 7);
        wr(7, 7, 7);
        wr(1, 0, 3);
        pulse_swap();
        cyc(2 * FRAME + 5);

        // reset in the middle of a row drive, then restart
        wait_fs(n);
        check("fs_seen_before_reset", int'(n > 0), 1);
        cyc(BL + 5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        wait_fs(n);
        check("fs_latency_after_reset", n, 1);
        cyc(FRAME);

        // merged swap requests inside one frame
        brightness = 4'hF;
        for (int i = 0; i < 8; i++) wr($urandom_range(0, R - 1), $urandom_range(0, C - 1), $urandom_range(1, 7));
        wait_fs(n);
        check("fs_seen_before_swap", int'(n > 0), 1);
        ack_cnt = 0;
        cyc(30);
        pulse_swap();
        cyc(20);
        pulse_swap();
        cyc(FRAME + 10);
`ifdef LED_MATRIX_DBUF_EN
        exp_ack = 1;
`else
        exp_ack = 0;
`endif
        check("swap_ack_count", ack_cnt, exp_ack);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            if (!enable) enable = ($urandom_range(0, 3) == 0);
            else         enable = ($urandom_range(0, 149) != 0);
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_row   = RW'($urandom_range(0, 7));
            wr_col   = CW'($urandom_range(0, 7));
            wr_color = CB'($urandom);
            swap_req = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) brightness = PW'($urandom);
        end
        @(negedge clk);
        rst      = 1'b0;
        wr_valid = 1'b0;
        swap_req = 1'b0;
        cyc(3);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
